tree_endpoint_ni: RTL and testbench

Endpoint network interface for the tree NoC, sitting on the endpoint side of one `chan_in_all`/`chan_out_all` pair. It is the counterpart of the leaf-router port:
- **Transmit:** packetizes requests into head/body/tail flits, computes the tree destination address (leaf position plus port) and injects under per-VC credit flow control.
- **Receive:** accepts ejected flits, presents them to the core and returns credits.

---
 rtl/tree_endpoint_ni.sv | 203 ++++++++++++++++++++
 tb/tb_tree_endpoint_ni.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tree_endpoint_ni.sv
// Tree NoC endpoint NI: packetizes requests into head/body/tail flits on a round-robin VC; ejected flits are registered and credited.
// Latency: handshake at T -> flit_out at T+1; flit_in at T -> rx_* and credit_out at T+1.
// Backpressure: per-VC credit counters gate pkt_ack/data_ready; the receive side never stalls. Option: TREE_NI_DSTCHK_EN.
module tree_endpoint_ni #(
    parameter int K     = 2,
    parameter int L     = 3,
    parameter int V     = 2,
    parameter int B     = 4,
    parameter int Dw    = 32,
    parameter int PLENw = 8,
    parameter int EP_ID = 0,
    localparam int Kw   = (K > 1) ? $clog2(K) : 1,
    localparam int NE   = K ** L,
    localparam int NEw  = $clog2(NE),
    localparam int LKw  = L * Kw,
    localparam int Fw   = 2 + V + Dw
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pkt_req,
    input  logic [NEw-1:0]   pkt_dst,
    input  logic [PLENw-1:0] pkt_len,
    output logic             pkt_ack,
    input  logic             data_valid,
    input  logic [Dw-1:0]    data,
    output logic             data_ready,
    output logic             flit_out_wr,
    output logic [Fw-1:0]    flit_out,
    input  logic [V-1:0]     credit_in,
    input  logic             flit_in_wr,
    input  logic [Fw-1:0]    flit_in,
    output logic [V-1:0]     credit_out,
    output logic             rx_valid,
    output logic             rx_head,
    output logic             rx_tail,
    output logic [V-1:0]     rx_vc,
    output logic [Dw-1:0]    rx_data,
    output logic             credit_err,
    output logic             misroute
);
    localparam int CNTw = $clog2(B + 1);
    localparam int VIw  = (V > 1) ? $clog2(V) : 1;

    typedef struct packed {
        logic          head;
        logic          tail;
        logic [V-1:0]  vc;
        logic [Dw-1:0] dat;
    } flit_t;

    typedef enum logic {IDLE, BODY} state_t;

    // {port, pos}: port is digit 0, leaf position digit i is digit i+1, top digit 0
    function automatic logic [Kw+LKw-1:0] encode_dst(input logic [NEw-1:0] dst);
        logic [Kw-1:0]  port;
        logic [LKw-1:0] pos;
        int unsigned    rem;
        rem  = 32'(dst);
        port = Kw'(rem % K);
        rem  = rem / K;
        pos  = '0;
        for (int i = 0; i < L - 1; i++) begin
            pos[i*Kw +: Kw] = Kw'(rem % K);
            rem = rem / K;
        end
        return {port, pos};
    endfunction

    state_t                    state_q, state_d;
    logic [V-1:0][CNTw-1:0]    credit_q;
    logic [V-1:0]              credit_avail;
    logic [VIw-1:0]            last_vc_q, cur_vc_q, rr_vc, cand, send_vc;
    logic                      rr_found;
    logic [PLENw-1:0]          remaining_q;
    logic                      send, send_head, send_tail;
    logic [Dw-1:0]             send_dat;
    flit_t                     flit_q, fin;

    always_comb begin
        for (int v = 0; v < V; v++) credit_avail[v] = (credit_q[v] != '0);
    end

    // Round-robin search starts just after the last VC that carried a packet
    always_comb begin
        rr_vc    = last_vc_q;
        rr_found = 1'b0;
        cand     = '0;
        for (int o = 1; o <= V; o++) begin
            cand = VIw'((int'(last_vc_q) + o) % V);
            if (!rr_found && credit_avail[cand]) begin
                rr_found = 1'b1;
                rr_vc    = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pkt_ack    = 1'b0;
        data_ready = 1'b0;
        send       = 1'b0;
        send_head  = 1'b0;
        send_tail  = 1'b0;
        send_vc    = cur_vc_q;
        send_dat   = data;
        case (state_q)
            IDLE: begin
                pkt_ack = pkt_req && rr_found;
                if (pkt_ack) begin
                    send      = 1'b1;
                    send_head = 1'b1;
                    send_vc   = rr_vc;
                    send_dat  = Dw'({NEw'(EP_ID), encode_dst(pkt_dst)});
                    send_tail = (pkt_len == '0);
                    if (pkt_len != '0) state_d = BODY;
                end
            end
            BODY: begin
                data_ready = data_valid && credit_avail[cur_vc_q];
                if (data_ready) begin
                    send      = 1'b1;
                    send_tail = (remaining_q == PLENw'(1));
                    if (send_tail) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_q    <= {V{CNTw'(B)}};
            credit_err  <= 1'b0;
            last_vc_q   <= VIw'(V - 1);
            cur_vc_q    <= '0;
            remaining_q <= '0;
            flit_out_wr <= 1'b0;
            flit_q      <= '0;
        end else begin
            for (int v = 0; v < V; v++) begin
                if (send && send_vc == VIw'(v) && !credit_in[v]) begin
                    credit_q[v] <= credit_q[v] - 1'b1;
                end else if (credit_in[v] && !(send && send_vc == VIw'(v))) begin
                    if (credit_q[v] == CNTw'(B)) credit_err <= 1'b1;
                    else                         credit_q[v] <= credit_q[v] + 1'b1;
                end
            end
            if (pkt_ack) begin
                last_vc_q   <= rr_vc;
                cur_vc_q    <= rr_vc;
                remaining_q <= pkt_len;
            end else if (data_ready) begin
                remaining_q <= remaining_q - 1'b1;
            end
            flit_out_wr <= send;
            if (send) flit_q <= '{head: send_head, tail: send_tail,
                                  vc: V'(1) << send_vc, dat: send_dat};
        end
    end

    assign flit_out = flit_q;
    assign fin      = flit_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_valid   <= 1'b0;
            rx_head    <= 1'b0;
            rx_tail    <= 1'b0;
            rx_vc      <= '0;
            rx_data    <= '0;
            credit_out <= '0;
        end else begin
            rx_valid   <= flit_in_wr;
            credit_out <= flit_in_wr ? fin.vc : '0;
            if (flit_in_wr) begin
                rx_head <= fin.head;
                rx_tail <= fin.tail;
                rx_vc   <= fin.vc;
                rx_data <= fin.dat;
            end
        end
    end

`ifdef TREE_NI_DSTCHK_EN
    logic [Kw+LKw-1:0] own_enc;
    assign own_enc = encode_dst(NEw'(EP_ID));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            misroute <= 1'b0;
        else if (flit_in_wr && fin.head && fin.dat[Kw+LKw-1:0] != own_enc)
            misroute <= 1'b1;
    end
`else
    assign misroute = 1'b0;
`endif

endmodule

// File: tb/tb_tree_endpoint_ni.sv
// Directed bench for tree_endpoint_ni (K=2, L=3, V=2, B=4, Dw=32, EP_ID=3).
module tb_tree_endpoint_ni;
`ifdef TREE_NI_DSTCHK_EN
    localparam logic EXP_MIS = 1'b1;
`else
    localparam logic EXP_MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pkt_req = 1'b0;
    logic [2:0]  pkt_dst = '0;
    logic [7:0]  pkt_len = '0;
    logic        pkt_ack;
    logic        data_valid = 1'b0;
    logic [31:0] data = '0;
    logic        data_ready;
    logic        flit_out_wr;
    logic [35:0] flit_out;
    logic [1:0]  credit_in = '0;
    logic        flit_in_wr = 1'b0;
    logic [35:0] flit_in = '0;
    logic [1:0]  credit_out;
    logic        rx_valid, rx_head, rx_tail;
    logic [1:0]  rx_vc;
    logic [31:0] rx_data;
    logic        credit_err, misroute;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    tree_endpoint_ni #(.K(2), .L(3), .V(2), .B(4), .Dw(32), .PLENw(8), .EP_ID(3)) dut (
        .clk(clk), .reset(reset),
        .pkt_req(pkt_req), .pkt_dst(pkt_dst), .pkt_len(pkt_len), .pkt_ack(pkt_ack),
        .data_valid(data_valid), .data(data), .data_ready(data_ready),
        .flit_out_wr(flit_out_wr), .flit_out(flit_out), .credit_in(credit_in),
        .flit_in_wr(flit_in_wr), .flit_in(flit_in), .credit_out(credit_out),
        .rx_valid(rx_valid), .rx_head(rx_head), .rx_tail(rx_tail), .rx_vc(rx_vc),
        .rx_data(rx_data), .credit_err(credit_err), .misroute(misroute)
    );

    typedef struct {
        string       name;
        logic        req;
        logic [2:0]  dst;
        logic [7:0]  len;
        logic        dv;
        logic [31:0] d;
        logic [1:0]  cin;
        logic        fwr;
        logic [35:0] fin;
        logic        e_ack;
        logic        e_rdy;
        logic        e_wr;
        logic [35:0] e_flit;
        logic [1:0]  e_cout;
        logic        e_rxv;
        logic [31:0] e_rxd;
        logic        e_err;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic idle_inputs();
        pkt_req = 1'b0; pkt_dst = '0; pkt_len = '0;
        data_valid = 1'b0; data = '0; credit_in = '0;
        flit_in_wr = 1'b0; flit_in = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    initial begin
        //              name        req dst len dv d             cin    fwr fin             ack rdy wr  flit            cout   rxv rxd            err
        vt[0] = '{"hdr",      1, 5, 2, 0, 32'h0,        2'b00, 0, 36'h0,          1, 0, 1, 36'h9_0000_003A, 2'b00, 0, 32'h0,     0};
        vt[1] = '{"body1",    0, 0, 0, 1, 32'h1111_1111, 2'b00, 0, 36'h0,          0, 1, 1, 36'h1_1111_1111, 2'b00, 0, 32'h0,     0};
        vt[2] = '{"body2",    0, 0, 0, 1, 32'h2222_2222, 2'b00, 0, 36'h0,          0, 1, 1, 36'h5_2222_2222, 2'b00, 0, 32'h0,     0};
        vt[3] = '{"rx",       0, 0, 0, 0, 32'h0,        2'b00, 1, 36'h2_0000_DEAD, 0, 0, 0, 36'h0,          2'b10, 1, 32'hDEAD, 0};
        vt[4] = '{"rx_after", 0, 0, 0, 0, 32'h0,        2'b00, 0, 36'h0,          0, 0, 0, 36'h0,          2'b00, 0, 32'h0,     0};
        vt[5] = '{"hdr_vc1",  1, 0, 0, 0, 32'h0,        2'b00, 0, 36'h0,          1, 0, 1, 36'hE_0000_0030, 2'b00, 0, 32'h0,     0};
        vt[6] = '{"hdr_vc0",  1, 7, 0, 0, 32'h0,        2'b00, 0, 36'h0,          1, 0, 1, 36'hD_0000_003B, 2'b00, 0, 32'h0,     0};
        vt[7] = '{"hdr_vc1b", 1, 6, 0, 0, 32'h0,        2'b00, 0, 36'h0,          1, 0, 1, 36'hE_0000_0033, 2'b00, 0, 32'h0,     0};
        vt[8] = '{"rr_skip",  1, 1, 0, 0, 32'h0,        2'b00, 0, 36'h0,          1, 0, 1, 36'hE_0000_0038, 2'b00, 0, 32'h0,     0};
        vt[9] = '{"crd_ret",  0, 0, 0, 0, 32'h0,        2'b01, 0, 36'h0,          0, 0, 0, 36'h0,          2'b00, 0, 32'h0,     0};

        // Reset state
        idle_inputs();
        #7;
        chk("rst_flit_out_wr", flit_out_wr, 0);
        chk("rst_flit_out", flit_out, 0);
        chk("rst_credit_out", credit_out, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_credit_err", credit_err, 0);
        chk("rst_misroute", misroute, 0);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            pkt_req = vt[i].req; pkt_dst = vt[i].dst; pkt_len = vt[i].len;
            data_valid = vt[i].dv; data = vt[i].d; credit_in = vt[i].cin;
            flit_in_wr = vt[i].fwr; flit_in = vt[i].fin;
            @(negedge clk);
            chk({vt[i].name, "_ack"}, pkt_ack, vt[i].e_ack);
            chk({vt[i].name, "_rdy"}, data_ready, vt[i].e_rdy);
            tick();
            idle_inputs();
            chk({vt[i].name, "_wr"}, flit_out_wr, vt[i].e_wr);
            if (vt[i].e_wr) chk({vt[i].name, "_flit"}, flit_out, vt[i].e_flit);
            chk({vt[i].name, "_cout"}, credit_out, vt[i].e_cout);
            chk({vt[i].name, "_rxv"}, rx_valid, vt[i].e_rxv);
            if (vt[i].e_rxv) chk({vt[i].name, "_rxd"}, rx_data, vt[i].e_rxd);
            chk({vt[i].name, "_err"}, credit_err, vt[i].e_err);
        end

        // Credit starvation: header + 3 bodies exhaust VC0, one credit buys one more flit
        do_reset();
        pkt_req = 1'b1; pkt_dst = 3'd2; pkt_len = 8'd5;
        @(negedge clk);
        chk("starve_ack", pkt_ack, 1);
        tick();
        pkt_req = 1'b0; data_valid = 1'b1; data = 32'hAAAA_0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("starve_rdy", data_ready, 1);
            tick();
            chk("starve_wr", flit_out_wr, 1);
        end
        @(negedge clk);
        chk("starve_blocked", data_ready, 0);
        tick();
        chk("starve_no_wr", flit_out_wr, 0);
        credit_in = 2'b01;
        @(negedge clk);
        chk("starve_credit_cycle", data_ready, 0);
        tick();
        credit_in = 2'b00;
        @(negedge clk);
        chk("starve_resume", data_ready, 1);
        tick();
        chk("starve_resume_wr", flit_out_wr, 1);
        chk("starve_resume_hdtl", flit_out[35:34], 2'b00);
        @(negedge clk);
        chk("starve_blocked2", data_ready, 0);
        tick();
        idle_inputs();

        // Simultaneous send and credit on VC0 leaves the counter at B
        do_reset();
        pkt_req = 1'b1; pkt_dst = 3'd0; pkt_len = 8'd0; credit_in = 2'b01;
        @(negedge clk);
        chk("simul_ack", pkt_ack, 1);
        tick();
        idle_inputs();
        chk("simul_no_err", credit_err, 0);
        credit_in = 2'b01;
        tick();
        credit_in = 2'b00;
        chk("vc0_full_err", credit_err, 1);

        // Overflow on VC1 is sticky
        do_reset();
        credit_in = 2'b10;
        tick();
        credit_in = 2'b00;
        chk("vc1_overflow_err", credit_err, 1);
        repeat (3) tick();
        chk("credit_err_sticky", credit_err, 1);

        // Destination check on received head flits
        do_reset();
        flit_in_wr = 1'b1; flit_in = 36'h9_0000_0009;
        tick();
        flit_in_wr = 1'b0;
        chk("dst_ok_misroute", misroute, 0);
        chk("dst_ok_head", rx_head, 1);
        flit_in_wr = 1'b1; flit_in = 36'h9_0000_0005;
        tick();
        flit_in_wr = 1'b0;
        chk("dst_bad_misroute", misroute, EXP_MIS);
        chk("dst_bad_credit", credit_out, 2'b01);
        tick();
        chk("dst_bad_sticky", misroute, EXP_MIS);

        // Reset in the middle of a packet
        do_reset();
        pkt_req = 1'b1; pkt_dst = 3'd5; pkt_len = 8'd3;
        @(negedge clk);
        chk("mid_ack", pkt_ack, 1);
        tick();
        pkt_req = 1'b0; data_valid = 1'b1; data = 32'h5555_5555;
        @(negedge clk);
        chk("mid_rdy", data_ready, 1);
        tick();
        chk("mid_body_wr", flit_out_wr, 1);
        #2;
        reset = 1'b0;
        idle_inputs();
        #1;
        chk("mid_rst_wr", flit_out_wr, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("mid_rst_no_tail", flit_out_wr, 0);
        credit_in = 2'b01;
        tick();
        credit_in = 2'b00;
        chk("mid_rst_credit_b", credit_err, 1);
        pkt_req = 1'b1; pkt_dst = 3'd0; pkt_len = 8'd0;
        @(negedge clk);
        chk("mid_rst_idle_ack", pkt_ack, 1);
        tick();
        idle_inputs();
        chk("mid_rst_vc0", flit_out[33:32], 2'b01);
        chk("mid_rst_head_tail", flit_out[35:34], 2'b11);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
